sram_arbiter: RTL

Shares the single external 256Kx8 asynchronous SRAM between two requesters. Port A is the Atom CPU: high priority, single-cycle strobe, one access per 1MHz CPU cycle. Port B is the bootstrap/ROM loader or a future DMA: low priority, level req/ack handshake. The block runs on the 100MHz system clock, generates all SRAM strobe timing, and drives the DAT tristate enable.

---
 rtl/sram_arbiter_pkg.sv | 18 +
 rtl/sram_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port external SRAM arbiter: default timing,
// address width and the access state encoding.
package sram_arbiter_pkg;

    localparam int SRAM_AW       = 18;
    localparam int RD_CYCLES_DEF = 2;
    localparam int WR_PULSE_DEF  = 2;
    localparam int CNT_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_e;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates the external asynchronous SRAM between the CPU (port A, strobe,
// high priority) and the loader/DMA (port B, level handshake, low priority).
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int AW        = SRAM_AW,
    parameter int RD_CYCLES = RD_CYCLES_DEF,
    parameter int WR_PULSE  = WR_PULSE_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_din,
    output logic [7:0]    a_dout,
    output logic          a_done,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_din,
    output logic [7:0]    b_dout,
    output logic          b_ack,
    output logic          busy,
    output logic          ram_cs_b,
    output logic          ram_oe_b,
    output logic          ram_we_b,
    output logic [AW-1:0] ram_a,
    output logic [7:0]    ram_dout,
    output logic          ram_doe,
    input  logic [7:0]    ram_din
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               own_b_q, own_b_d;
    logic               a_pend_q, a_pend_d;
    logic               ah_we_q, ah_we_d;
    logic [AW-1:0]      ah_addr_q, ah_addr_d;
    logic [7:0]         ah_din_q, ah_din_d;
    logic [AW-1:0]      ram_a_q, ram_a_d;
    logic [7:0]         ram_dout_q, ram_dout_d;
    logic [7:0]         a_dout_q, a_dout_d;
    logic [7:0]         b_dout_q, b_dout_d;
    logic               a_done_q, a_done_d;
    logic               b_ack_q, b_ack_d;
    logic               busy_q, busy_d;
    logic               cs_b_q, cs_b_d;
    logic               oe_b_q, oe_b_d;
    logic               we_b_q, we_b_d;
    logic               doe_q, doe_d;

    logic               b_block;
    logic               sel_a;
    logic               go_we;
    logic [AW-1:0]      go_addr;
    logic [7:0]         go_din;

    // A held b_req is still high on the ack cycle; suppress re-grant there.
    assign b_block = b_ack_q;

    // Newest A request wins; the bypass path serves a fresh strobe directly.
    assign sel_a   = a_req || a_pend_q;
    assign go_we   = !sel_a ? b_we   : (a_req ? a_we   : ah_we_q);
    assign go_addr = !sel_a ? b_addr : (a_req ? a_addr : ah_addr_q);
    assign go_din  = !sel_a ? b_din  : (a_req ? a_din  : ah_din_q);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        own_b_d    = own_b_q;
        a_pend_d   = a_pend_q;
        ah_we_d    = ah_we_q;
        ah_addr_d  = ah_addr_q;
        ah_din_d   = ah_din_q;
        ram_a_d    = ram_a_q;
        ram_dout_d = ram_dout_q;
        a_dout_d   = a_dout_q;
        b_dout_d   = b_dout_q;
        a_done_d   = 1'b0;
        b_ack_d    = 1'b0;

        if (a_req) begin
            a_pend_d  = 1'b1;
            ah_we_d   = a_we;
            ah_addr_d = a_addr;
            ah_din_d  = a_din;
        end

        case (state_q)
            ST_IDLE: begin
                if (sel_a || (b_req && !b_block)) begin
                    own_b_d  = !sel_a;
                    a_pend_d = sel_a ? 1'b0 : a_pend_d;
                    ram_a_d  = go_addr;
                    if (go_we) begin
                        ram_dout_d = go_din;
                        state_d    = ST_WR_SETUP;
                    end else begin
                        cnt_d   = CNT_W'(RD_CYCLES - 1);
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (cnt_q == '0) begin
                    if (own_b_q) begin
                        b_dout_d = ram_din;
                        b_ack_d  = 1'b1;
                    end else begin
                        a_dout_d = ram_din;
                        a_done_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_SETUP: begin
                cnt_d   = CNT_W'(WR_PULSE - 1);
                state_d = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (cnt_q == '0) state_d = ST_WR_HOLD;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_WR_HOLD: begin
                b_ack_d  = own_b_q;
                a_done_d = !own_b_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes are registered from the next state so they line up with it.
        cs_b_d = (state_d == ST_IDLE);
        oe_b_d = (state_d != ST_RD);
        we_b_d = (state_d != ST_WR_PULSE);
        doe_d  = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
                 (state_d == ST_WR_HOLD);
        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            own_b_q    <= 1'b0;
            a_pend_q   <= 1'b0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            a_dout_q   <= '0;
            b_dout_q   <= '0;
            a_done_q   <= 1'b0;
            b_ack_q    <= 1'b0;
            busy_q     <= 1'b0;
            cs_b_q     <= 1'b1;
            oe_b_q     <= 1'b1;
            we_b_q     <= 1'b1;
            doe_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            own_b_q    <= own_b_d;
            a_pend_q   <= a_pend_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= ram_dout_d;
            a_dout_q   <= a_dout_d;
            b_dout_q   <= b_dout_d;
            a_done_q   <= a_done_d;
            b_ack_q    <= b_ack_d;
            busy_q     <= busy_d;
            cs_b_q     <= cs_b_d;
            oe_b_q     <= oe_b_d;
            we_b_q     <= we_b_d;
            doe_q      <= doe_d;
        end
    end

    // NOTE: the held request payload needs no reset; a_pend_q qualifies it.
    always_ff @(posedge clk) begin
        ah_we_q   <= ah_we_d;
        ah_addr_q <= ah_addr_d;
        ah_din_q  <= ah_din_d;
    end

    assign a_dout   = a_dout_q;
    assign a_done   = a_done_q;
    assign b_dout   = b_dout_q;
    assign b_ack    = b_ack_q;
    assign busy     = busy_q;
    assign ram_cs_b = cs_b_q;
    assign ram_oe_b = oe_b_q;
    assign ram_we_b = we_b_q;
    assign ram_a    = ram_a_q;
    assign ram_dout = ram_dout_q;
    assign ram_doe  = doe_q;

    // Bus-safety invariants of the SRAM interface.
    a_oe_no_drive: assert property (@(posedge clk) disable iff (reset)
        !ram_oe_b |-> !ram_doe);
    a_we_drive_cs: assert property (@(posedge clk) disable iff (reset)
        !ram_we_b |-> (ram_doe && !ram_cs_b));
    a_addr_stable: assert property (@(posedge clk) disable iff (reset)
        (!ram_cs_b && $past(!ram_cs_b)) |-> ($stable(ram_a) && $stable(ram_dout)));

endmodule
